// File: rtl/alu_defs.sv
// Shared ALU opcodes and multiplier FSM encodings.
package alu_defs;

  localparam int unsigned XLEN = 64;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_NOR    = 4'b1100;
  localparam logic [3:0] ALU_LESSER = 4'b1000;
  localparam logic [3:0] ALU_LSHIFT = 4'b0111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/alu_64.sv
// 64-bit combinational ALU shared by the execute stage.
module alu_64
  import alu_defs::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ALUOp,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            is_greater
);

  always_comb begin
    Result = '0;
    case (ALUOp)
      ALU_AND:    Result = a & b;
      ALU_OR:     Result = a | b;
      ALU_ADD:    Result = a + b;
      ALU_SUB:    Result = a - b;
      ALU_NOR:    Result = ~(a | b);
      ALU_LESSER: Result = {63'd0, $signed(a) < $signed(b)};
      ALU_LSHIFT: Result = a << b[5:0];
      default:    Result = '0;
    endcase
  end

  assign Zero       = (Result == '0);
  assign is_greater = ($signed(a) > $signed(b));

endmodule

// File: rtl/alu_seq_mul.sv
// Shift-and-add 64x64 -> low-64 multiplier
// that time-shares a single alu_64.
module alu_seq_mul
  import alu_defs::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [5:0]      iter_q, iter_d;

  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_a, alu_b, alu_res;

  alu_64 u_alu (
    .a          (alu_a),
    .b          (alu_b),
    .ALUOp      (alu_op),
    .Result     (alu_res),
    .Zero       (),
    .is_greater ()
  );

  always_comb begin
    alu_op = ALU_AND;
    alu_a  = '0;
    alu_b  = '0;
    unique case (state_q)
      S_ADD: begin
        alu_op = ALU_ADD;
        alu_a  = acc_q;
        alu_b  = mplier_q[0] ? mcand_q : '0;
      end
      S_SHIFT: begin
        alu_op = ALU_LSHIFT;
        alu_a  = mcand_q;
        alu_b  = 64'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          iter_d   = '0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        acc_d   = alu_res;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        mcand_d  = alu_res;
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + 6'd1;
        // Early exit looks at the multiplier as it will be after this shift
        if (iter_q == 6'd63 ||
            (EARLY_EXIT && mplier_q[XLEN-1:1] == '0))
          state_d = S_DONE;
        else
          state_d = S_ADD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = acc_q;

endmodule

// File: tb/tb_alu_seq_mul.sv
// Scoreboard bench for alu_seq_mul:
// early-exit and full-length builds side by side.
module tb_alu_seq_mul;

  typedef struct {
    logic [63:0] r;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start1 = 1'b0, start0 = 1'b0;
  logic [63:0] a1 = '0, b1 = '0, a0 = '0, b0 = '0;
  logic        busy1, done1, busy0, done0;
  logic [63:0] result1, result0;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q0[$];
  bit   pend1 = 0, pend0 = 0;

  alu_seq_mul #(.EARLY_EXIT(1'b1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start1),
    .a       (a1),
    .b       (b1),
    .busy    (busy1),
    .done    (done1),
    .result  (result1)
  );

  alu_seq_mul #(.EARLY_EXIT(1'b0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start0),
    .a       (a0),
    .b       (b0),
    .busy    (busy0),
    .done    (done0),
    .result  (result0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic int n_iter(input logic [63:0] bb,
                                input bit early);
    int n;
    if (!early) return 64;
    n = 1;
    for (int i = 0; i < 64; i++)
      if (bb[i]) n = i + 1;
    return n;
  endfunction

  task automatic mon(input int id, input logic d,
                     input logic bz,
                     input logic [63:0] r,
                     inout bit pend);
    exp_t e;
    int   qs;
    if (pend) begin
      chk($sformatf("busy_fall%0d", id), {63'd0, bz}, 64'd0);
      pend = 0;
    end
    if (reset_n && d) begin
      qs = (id == 1) ? q1.size() : q0.size();
      checks++;
      if (qs == 0) begin
        errors++;
        $display("FAIL spurious_done%0d: got done=1 expected 0 at cycle %0d",
                 id, cyc);
      end else begin
        e = (id == 1) ? q1.pop_front() : q0.pop_front();
        chk($sformatf("result%0d", id), r, e.r);
        chk($sformatf("done_cycle%0d", id), 64'(cyc), 64'(e.c));
        pend = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1, done1, busy1, result1, pend1);
    mon(0, done0, busy0, result0, pend0);
  end

  task automatic issue(input int id,
                       input logic [63:0] aa,
                       input logic [63:0] bb);
    exp_t e;
    int   k;
    k = 0;
    @(negedge clk);
    while ((id == 1 ? busy1 : busy0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout%0d: busy stuck, expected idle", id);
      return;
    end
    e.r = aa * bb;
    e.c = cyc + 1 + 2 * n_iter(bb, id == 1);
    if (id == 1) begin
      a1 = aa; b1 = bb; start1 = 1'b1;
      q1.push_back(e);
    end else begin
      a0 = aa; b0 = bb; start0 = 1'b1;
      q0.push_back(e);
    end
    @(negedge clk);
    // scramble operands once captured; they must not matter
    if (id == 1) begin
      start1 = 1'b0;
      a1 = {$urandom, $urandom};
      b1 = {$urandom, $urandom};
    end else begin
      start0 = 1'b0;
      a0 = {$urandom, $urandom};
      b0 = {$urandom, $urandom};
    end
  endtask

  function automatic logic [63:0] rnd_b();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v >> $urandom_range(63, 0);
  endfunction

  initial begin
    int k;
    #1;
    chk("rst_busy1", {63'd0, busy1}, 64'd0);
    chk("rst_done1", {63'd0, done1}, 64'd0);
    chk("rst_result1", result1, 64'd0);
    chk("rst_busy0", {63'd0, busy0}, 64'd0);
    chk("rst_done0", {63'd0, done0}, 64'd0);
    chk("rst_result0", result0, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    issue(1, 64'd3, 64'd5);
    issue(1, 64'h1234, 64'd0);
    issue(1, '1, '1);

    issue(1, 64'd7, 64'd9);
    @(negedge clk);
    start1 = 1'b1; a1 = 64'd100; b1 = 64'd100;
    repeat (2) @(negedge clk);
    start1 = 1'b0;

    issue(1, 64'd3, 64'd5);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy1", {63'd0, busy1}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy1", {63'd0, busy1}, 64'd0);
    chk("mid_rst_done1", {63'd0, done1}, 64'd0);
    chk("mid_rst_result1", result1, 64'd0);
    q1.delete();
    pend1 = 0;
    @(negedge clk);
    reset_n = 1'b1;
    issue(1, 64'd2, 64'd2);

    for (int i = 0; i < 30; i++)
      issue(1, {$urandom, $urandom}, rnd_b());
    issue(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001);

    issue(0, 64'd3, 64'd5);
    issue(0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
    for (int i = 0; i < 4; i++)
      issue(0, {$urandom, $urandom}, rnd_b());

    k = 0;
    while ((q1.size() != 0 || q0.size() != 0 ||
            busy1 || busy0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0",
               q1.size(), q0.size());
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
